// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// byte-packing constants.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_BITS  = 2;

  localparam logic [BYTE_CNT_BITS-1:0] LAST_BYTE = BYTE_CNT_BITS'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the loader: a transfer happens when
// byte_valid && byte_ready on a rising clock edge.
interface imem_loader_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input  byte_ready);
  modport slave  (input  byte_valid, input  byte_data, output byte_ready);

endinterface

// File: rtl/imem_loader_store.sv
// Instruction storage: one synchronous write port for the loader and one
// combinational read port shared with the fetch stage.
module imem_store #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 sel,
  output logic [DATA_BITS-1:0] dout
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  // NOTE: the array is deliberately left out of reset so it maps onto RAM;
  // a program loaded before a reset survives it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A write on this edge is only visible after it, so a same-cycle read
  // returns the previous word.
  assign dout = sel ? mem[addr] : '0;

endmodule

// File: rtl/imem_loader.sv
// Run-time program loader: packs a big-endian byte stream into 32-bit words,
// writes them from address 0 and holds the core while the load is running.
module imem_loader #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [ADDR_BITS:0]   load_len,
  imem_loader_if.slave         bs,
  output logic                 busy,
  output logic                 done,
  output logic                 cpu_hold,
  output logic [ADDR_BITS-1:0] load_addr,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 sel,
  output logic [DATA_BITS-1:0] dout
);

  import imem_loader_pkg::*;

  localparam logic [ADDR_BITS:0]         DEPTH_LEN = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]         LEN_ONE   = 1;
  localparam logic [ADDR_BITS-1:0]       ADDR_ONE  = 1;
  localparam logic [BYTE_CNT_BITS-1:0]   CNT_ONE   = 1;

  state_t                   state;
  logic [BYTE_CNT_BITS-1:0] byte_cnt;
  logic [DATA_BITS-9:0]     asm_word;   // first three bytes of the word in flight
  logic [ADDR_BITS:0]       len_q;
  logic [ADDR_BITS:0]       sat_len;
  logic                     byte_ready_q;
  logic                     accept;
  logic                     word_done;
  logic                     last_word;

  // NOTE: every always_comb output gets a default before any condition so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sat_len = load_len;
    if (load_len > DEPTH_LEN) sat_len = DEPTH_LEN;
  end

  assign bs.byte_ready = byte_ready_q;
  assign accept        = bs.byte_valid && byte_ready_q;
  assign word_done     = accept && (byte_cnt == LAST_BYTE);
  assign last_word     = (({1'b0, load_addr}) + LEN_ONE) == len_q;
  assign cpu_hold      = busy;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      asm_word     <= '0;
      len_q        <= '0;
      load_addr    <= '0;
      byte_ready_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load_start) begin
            busy      <= 1'b1;
            load_addr <= '0;
            byte_cnt  <= '0;
            asm_word  <= '0;
            len_q     <= sat_len;
            if (load_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state        <= LOAD;
              byte_ready_q <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (word_done) begin
            load_addr <= load_addr + ADDR_ONE;
            byte_cnt  <= '0;
            if (last_word) begin
              state        <= DONE;
              done         <= 1'b1;
              byte_ready_q <= 1'b0;
            end
          end else if (accept) begin
            asm_word <= {asm_word[DATA_BITS-17:0], bs.byte_data};
            byte_cnt <= byte_cnt + CNT_ONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state        <= IDLE;
          byte_ready_q <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

  imem_store #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_store (
    .clk   (clk),
    .we    (word_done),
    .waddr (load_addr),
    .wdata ({asm_word, bs.byte_data}),
    .addr  (addr),
    .sel   (sel),
    .dout  (dout)
  );

endmodule
